// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM condition-check and NZCV flags-register stage
//
// Holds the architectural NZCV flags, evaluates the 4-bit ARM condition of
// the issuing instruction, gates the decoder write/branch controls and commits
// ALU flags from flag-setting instructions one cycle after issue.
//
// Compile-time option: COND_FLAG_BYPASS_EN
//   defined   - pending ALU flags are forwarded into the condition check, no stall
//   undefined - a dependent conditional instruction is stalled for one cycle
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   valid, cond       issue strobe and ARM condition field
//   flag_w            [1] update N,Z  [0] update C,V
//   pcs, reg_w, mem_w ungated decoder controls
//   alu_flags         ALU {N,Z,C,V}, valid the cycle after issue
//   pc_src, reg_write, mem_write  gated controls
//   cond_ex           accepted instruction passed its condition
//   stall             issue not accepted this cycle
//   flags             architectural {N,Z,C,V}
//   skip_cnt          saturating count of accepted, condition-failed instructions

module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [3:0]       cond,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic [3:0]       alu_flags,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic             stall,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] skip_cnt
);

  logic [3:0]       flags_q;
  logic [1:0]       pend;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       ef;
  logic             stall_i;
  logic             cond_true;
  logic             accept;
  logic             cex;

`ifdef COND_FLAG_BYPASS_EN
  // Fields still waiting to be committed are taken straight from the ALU.
  always_comb begin
    ef      = flags_q;
    stall_i = 1'b0;
    if (pend[1]) ef[3:2] = alu_flags[3:2];
    if (pend[0]) ef[1:0] = alu_flags[1:0];
  end
`else
  // Any pending update makes the flags stale for a conditional instruction;
  // AL/NV (111x) never reads them, so it is not held back.
  always_comb begin
    ef      = flags_q;
    stall_i = valid & (pend != 2'b00) & (cond[3:1] != 3'b111);
  end
`endif

  always_comb begin
    cond_true = 1'b1;
    unique case (cond)
      4'b0000: cond_true = ef[2];
      4'b0001: cond_true = ~ef[2];
      4'b0010: cond_true = ef[1];
      4'b0011: cond_true = ~ef[1];
      4'b0100: cond_true = ef[3];
      4'b0101: cond_true = ~ef[3];
      4'b0110: cond_true = ef[0];
      4'b0111: cond_true = ~ef[0];
      4'b1000: cond_true = ef[1] & ~ef[2];
      4'b1001: cond_true = ~ef[1] | ef[2];
      4'b1010: cond_true = (ef[3] == ef[0]);
      4'b1011: cond_true = (ef[3] != ef[0]);
      4'b1100: cond_true = ~ef[2] & (ef[3] == ef[0]);
      4'b1101: cond_true = ef[2] | (ef[3] != ef[0]);
      default: cond_true = 1'b1;
    endcase
  end

  // Reset masks every output, combinational ones included.
  assign accept    = valid & ~stall_i & ~reset;
  assign cex       = accept & cond_true;
  assign cond_ex   = cex;
  assign pc_src    = pcs & cex;
  assign reg_write = reg_w & cex;
  assign mem_write = mem_w & cex;
  assign stall     = stall_i & ~reset;
  assign flags     = reset ? 4'b0000 : flags_q;
  assign skip_cnt  = reset ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      pend    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      // Commit uses the pend captured on the previous edge.
      if (pend[1]) flags_q[3:2] <= alu_flags[3:2];
      if (pend[0]) flags_q[1:0] <= alu_flags[1:0];
      pend <= cex ? flag_w : 2'b00;
      if (accept && !cond_true && !(&cnt_q))
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit

module tb_cond_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef COND_FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             valid;
  logic [3:0]       cond;
  logic [1:0]       flag_w;
  logic             pcs, reg_w, mem_w;
  logic [3:0]       alu_flags;
  logic             pc_src, reg_write, mem_write, cond_ex, stall;
  logic [3:0]       flags;
  logic [CNT_W-1:0] skip_cnt;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid(valid), .cond(cond), .flag_w(flag_w),
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .alu_flags(alu_flags),
    .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
    .cond_ex(cond_ex), .stall(stall), .flags(flags), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: committed flags, which fields await an ALU result, skip count.
  logic [3:0] m_flags;
  logic [1:0] m_pend;
  int         m_cnt;

  // Values sampled in the last step's issue cycle, for directed checks.
  logic o_pc_src, o_reg_write, o_mem_write, o_cond_ex, o_stall;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ARM rule: even codes test a predicate, odd codes test its negation; 111x always.
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (int'(c) / 2)
      0: r = z;
      1: r = cy;
      2: r = n;
      3: r = v;
      4: r = cy && !z;
      5: r = (n == v);
      6: r = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic logic [3:0] merge(input logic [3:0] base, input logic [3:0] alu,
                                       input logic [1:0] m);
    return {m[1] ? alu[3:2] : base[3:2], m[0] ? alu[1:0] : base[1:0]};
  endfunction

  task automatic step(input logic v, input logic [3:0] c, input logic [1:0] fw,
                      input logic p, input logic rw, input logic mw, input logic [3:0] alu);
    bit e_stall, e_cex, pass;
    logic [3:0] eff;
    valid = v; cond = c; flag_w = fw; pcs = p; reg_w = rw; mem_w = mw; alu_flags = alu;
    #2;
    if (reset) begin
      e_stall = 0; e_cex = 0;
      chk("rst_flags", 16'(flags), 16'h0);
      chk("rst_skip", 16'(skip_cnt), 16'h0);
    end else begin
      eff     = BYPASS ? merge(m_flags, alu, m_pend) : m_flags;
      pass    = m_cond(c, eff);
      e_stall = !BYPASS && v && (m_pend != 2'b00) && (c < 4'd14);
      e_cex   = v && !e_stall && pass;
      chk("flags_pre", 16'(flags), 16'(m_flags));
      chk("skip_pre", 16'(skip_cnt), 16'(m_cnt));
    end
    o_pc_src = pc_src; o_reg_write = reg_write; o_mem_write = mem_write;
    o_cond_ex = cond_ex; o_stall = stall;
    chk("stall", 16'(stall), 16'(e_stall));
    chk("cond_ex", 16'(cond_ex), 16'(e_cex));
    chk("pc_src", 16'(pc_src), 16'(p && e_cex));
    chk("reg_write", 16'(reg_write), 16'(rw && e_cex));
    chk("mem_write", 16'(mem_write), 16'(mw && e_cex));
    @(posedge clk);
    if (reset) begin
      m_flags = 4'b0000; m_pend = 2'b00; m_cnt = 0;
    end else begin
      m_flags = merge(m_flags, alu, m_pend);
      if (v && !e_stall && !e_cex && m_cnt < CNT_MAX) m_cnt++;
      m_pend = e_cex ? fw : 2'b00;
    end
    #1;
  endtask

  int base_cnt;

  initial begin
    m_flags = 0; m_pend = 0; m_cnt = 0;
    reset = 1'b1;

    // Reset held with live controls: everything reads zero.
    step(1, 4'hE, 2'b11, 1, 1, 1, 4'hF);
    step(1, 4'hE, 2'b11, 1, 1, 1, 4'hF);
    chk("rst_outs", 16'({o_pc_src, o_reg_write, o_mem_write, o_cond_ex, o_stall}), 16'h0);
    reset = 1'b0;
    step(0, 4'hE, 2'b00, 0, 0, 0, 4'hF);
    step(0, 4'hE, 2'b00, 0, 0, 0, 4'hF);
    chk("post_rst_flags", 16'(flags), 16'h0);

    // Flag commit, two edges after issue.
    step(1, 4'hE, 2'b11, 0, 1, 0, 4'h0);
    chk("commit_regw", 16'(o_reg_write), 16'h1);
    step(0, 4'hE, 2'b00, 0, 0, 0, 4'b0100);
    chk("commit_flags", 16'(flags), 16'b0100);

    // Partial update: establish 0011, then update N,Z only.
    step(1, 4'hE, 2'b11, 0, 0, 0, 4'h0);
    step(0, 4'hE, 2'b00, 0, 0, 0, 4'b0011);
    chk("preset_0011", 16'(flags), 16'b0011);
    step(1, 4'hE, 2'b10, 0, 0, 0, 4'h0);
    step(0, 4'hE, 2'b00, 0, 0, 0, 4'b0100);
    chk("partial_flags", 16'(flags), 16'b0111);

    // Flag hazard: flag-setting AL then EQ branch on the new Z.
    step(1, 4'hE, 2'b11, 0, 0, 0, 4'h0);
    step(1, 4'h0, 2'b00, 1, 0, 0, 4'b0100);
    if (BYPASS) begin
      chk("byp_stall", 16'(o_stall), 16'h0);
      chk("byp_pc_src", 16'(o_pc_src), 16'h1);
    end else begin
      chk("hz_stall", 16'(o_stall), 16'h1);
      chk("hz_pc_src", 16'(o_pc_src), 16'h0);
      step(1, 4'h0, 2'b00, 1, 0, 0, 4'b0100);
      chk("hz2_stall", 16'(o_stall), 16'h0);
      chk("hz2_pc_src", 16'(o_pc_src), 16'h1);
    end

    // Condition fail: flags 0000, EQ with flag_w=11 must not touch flags.
    step(1, 4'hE, 2'b11, 0, 0, 0, 4'h0);
    step(0, 4'hE, 2'b00, 0, 0, 0, 4'b0000);
    base_cnt = int'(skip_cnt);
    step(1, 4'h0, 2'b11, 0, 1, 0, 4'h0);
    chk("fail_regw", 16'(o_reg_write), 16'h0);
    chk("fail_cex", 16'(o_cond_ex), 16'h0);
    step(0, 4'hE, 2'b00, 0, 0, 0, 4'b1111);
    chk("fail_flags", 16'(flags), 16'h0);
    chk("fail_skip", 16'(skip_cnt), 16'(base_cnt + 1));

    // Saturation of the skip counter.
    for (int i = 0; i < CNT_MAX + 4; i++) step(1, 4'h0, 2'b11, 0, 1, 0, 4'hF);
    chk("skip_sat", 16'(skip_cnt), 16'(CNT_MAX));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      step($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 4'($urandom));
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
